div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk input, rst input.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  EX requests a divide; held high until the result is consumed.
REQ-005 signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
REQ-006 opdata1_i  input  32  dividend (rs value).
REQ-007 opdata2_i  input  32  divisor (rt value).
REQ-008 annul_i  input  1  cancels any in-flight divide (flush).
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}; the HI/LO write data.
REQ-010 ready_o  output  1  result_o is valid.
REQ-011 stallreq_o  output  1  stall request to the pipeline stall controller, for the EX stage.

Function
REQ-012 The FSM SHALL have four states: IDLE, DIVZERO, ON, END.
REQ-013 IDLE: when start_i=1 and annul_i=0 at edge k, the block SHALL latch the operands and signed_div_i.
- If opdata2_i==0 → DIVZERO.
- Otherwise → ON, with cnt=0 and the partial remainder cleared.
REQ-014 When signed_div_i=1, operands SHALL be latched as magnitudes, and the negate-quotient and negate-remainder flags SHALL be recorded.
- Quotient sign = dividend sign XOR divisor sign.
- Remainder sign = dividend sign.
REQ-015 ON: each edge SHALL perform one restoring-division step: shift in the next dividend bit, trial-subtract a 33-bit value, set a quotient bit, and increment cnt (6-bit).
REQ-016 ON with cnt==32: at the next edge the block SHALL apply the sign fixes, register result_o, and go to END.
- Latency: ON after edge k; steps at edges k+1..k+32; result_o loaded and END entered at edge k+33.
REQ-017 DIVZERO: at the next edge the block SHALL set result_o = 64'h0 and go to END.
- Latency: END entered at edge k+1.
REQ-018 END: the block SHALL hold result_o stable while start_i=1, and return to IDLE on the first edge with start_i=0.
REQ-019 ready_o SHALL equal (state==END).
REQ-020 stallreq_o SHALL equal start_i & ~annul_i & (state!=END), combinationally.
- The pipeline therefore freezes in the cycle the request first appears.
REQ-021 annul_i=1 in ON or DIVZERO SHALL force IDLE at the next edge.
- result_o is not updated.
- ready_o never asserts for that divide.
REQ-022 annul_i=1 in END SHALL force IDLE at the next edge.
REQ-023 annul_i has priority over start_i in every state.
REQ-024 In the signed case 0x80000000 / 0xFFFFFFFF, the result SHALL be quotient 0x80000000 (wrap) and remainder 0.
- No trap or flag is raised.
REQ-025 Operand changes on opdata1_i/opdata2_i after the latch edge SHALL NOT affect the running divide.
REQ-026 A new start_i SHALL only be accepted from IDLE.
- Back-to-back divides therefore need at least one cycle with start_i=0 in END.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, cnt=0, result_o=64'h0 and operand registers=0.
- ready_o=0 from that edge.
- stallreq_o follows REQ-020 combinationally.
REQ-028 Reset mid-divide (in ON) SHALL discard all partial state.
- The next start after reset deassertion SHALL produce a correct, independent result.

Verification
REQ-029 Unsigned divide: start_i=1 held, signed_div_i=0, 100 / 7.
- ready_o rises at edge k+33.
- result_o = {32'd2, 32'd14}.
- stallreq_o is high from cycle k through k+32 and low once END is reached.
REQ-030 Signed divide: signed_div_i=1, 0xFFFFFFF9 (−7) / 2.
- result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-031 Divide by zero: opdata2_i=0, start_i=1 at edge k.
- END entered at k+1 with result_o = 64'h0.
- stallreq_o is high only in cycle k.
REQ-032 Annul mid-divide: annul_i=1 pulsed at edge k+10.
- State is IDLE at k+11.
- ready_o never asserts.
- stallreq_o=0 while annul_i=1.
- A following 100/7 still yields {2,14}.
REQ-033 Reset mid-divide: rst at edge k+5 → IDLE and result_o=0; a fresh start of 0x80000000 / 0xFFFFFFFF, signed, → {32'h0, 32'h80000000}.
REQ-034 Result consumption and restart: hold start_i=1 in END for 3 cycles.
- result_o and ready_o are stable throughout.
- Dropping start_i → IDLE next edge and ready_o=0.
- A restart one cycle later with unsigned 0xFFFFFFFF / 1 → {32'h0, 32'hFFFFFFFF}.

Source files
------------

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - 32-bit multi-cycle restoring divider for the EX stage
// Signed divides run on magnitudes; signs are reapplied when the result is registered.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // r_dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign w_shift   = {r_rem, r_dvd[31]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[32];

  assign w_quo_fix = r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
  assign w_rem_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

  assign ready_o    = (r_state == S_END);
  assign stallreq_o = start_i & ~annul_i & (r_state != S_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= 64'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_dvd   <= w_op1_mag;
            r_dvs   <= w_op2_mag;
            r_rem   <= 32'd0;
            r_cnt   <= 6'd0;
            r_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r <= signed_div_i & opdata1_i[31];
            r_state <= (opdata2_i == 32'd0) ? S_DIVZERO : S_ON;
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            result_o <= 64'h0;
            r_state  <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 6'd32) begin
            result_o <= {w_rem_fix, w_quo_fix};
            r_state  <= S_END;
          end else begin
            r_rem <= w_qbit ? w_trial[31:0] : w_shift[31:0];
            r_dvd <= {r_dvd[30:0], w_qbit};
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_END: begin
          if (annul_i || !start_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with directed divide vectors
// Stimulus pushes expected results; a negedge monitor pops and compares on ready_o rising.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 0;
  bit   chk_res0 = 0;
  bit   exp_stall = 0;
  bit   exp_ready = 0;
  bit   done = 0;
  bit   fin = 0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: the only process that compares or touches the counters.
  initial begin
    exp_t cur;
    bit   have;
    bit   prev_rdy;
    have     = 0;
    prev_rdy = 0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        cmp("stallreq", 64'(stallreq_o), 64'(exp_stall));
        cmp("ready", 64'(ready_o), 64'(exp_ready));
      end
      if (chk_res0) cmp("result_zero", result_o, 64'h0);
      if (ready_o === 1'b1 && !prev_rdy) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          have = 0;
          $display("FAIL spurious_ready at cycle %0d: got result %h, expected no ready", cyc, result_o);
        end else begin
          cur  = sb.pop_front();
          have = 1;
          cmp("result", result_o, cur.res);
          cmp("ready_cycle", 64'(cyc), 64'(cur.cyc));
        end
      end else if (ready_o === 1'b1 && have) begin
        cmp("result_hold", result_o, cur.res);
      end
      prev_rdy = (ready_o === 1'b1);
      if (done && !fin) begin
        cmp("scoreboard_left", 64'(sb.size()), 64'h0);
        fin = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide, scramble operands after the latch edge, hold in END, then release.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input int lat, input int hold);
    exp_t e;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    exp_stall    = 1'b1;
    exp_ready    = 1'b0;
    e.res        = exp;
    e.cyc        = cyc + 1 + lat;
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      step();
      if (i == 0) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    step();
    exp_stall = 1'b0;
    exp_ready = 1'b1;
    for (int i = 0; i < hold; i++) step();
    start_i = 1'b0;
    step();
    exp_ready = 1'b0;
    step();
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    annul_i      = 1'b0;
    step();
    step();
    chk_on   = 1;
    chk_res0 = 1;
    step();
    rst = 1'b0;
    step();
    chk_res0 = 0;

    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 3);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, 0);
    run_div(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, {32'hFFFFFFFF, 32'd3}, 33, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, 33, 0);
    run_div(32'd1234, 32'd0, 1'b0, 64'h0, 1, 2);

    // Annul wins over start while idle.
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    exp_stall = 1'b0;
    step();
    step();
    start_i = 1'b0;
    annul_i = 1'b0;
    step();

    // Annul mid-divide: annul sampled at edge k+10.
    start_i   = 1'b1;
    exp_stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    annul_i   = 1'b1;
    exp_stall = 1'b0;
    step();
    annul_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);

    // Reset mid-divide: reset sampled at edge k+5.
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd999;
    opdata2_i    = 32'd3;
    exp_stall    = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst       = 1'b1;
    start_i   = 1'b0;
    exp_stall = 1'b0;
    step();
    chk_res0 = 1;
    rst      = 1'b0;
    step();
    step();
    chk_res0 = 0;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 0);

    done = 1;
    for (int i = 0; i < 5 && !fin; i++) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
